// File: rtl/pythag_leg_solver.sv
// Recovers the missing leg Y = sqrt(R*R - X*X) with a restoring, one-bit-per-cycle root.
// Optional build macro ROUND_HALF_EN rounds the root to nearest instead of truncating.
module pythag_leg_solver #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] r_in,
  input  logic [WIDTH-1:0] x_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_out,
  output logic             err_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StSquare, StRoot, StRound, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     r_q, x_q, root_q, y_q;
  logic [2*WIDTH-1:0]   rad_q;
  logic [WIDTH+1:0]     rem_q;
  logic [CntW-1:0]      cnt_q;
  logic                 in_ready_q, out_valid_q, err_q;

  logic [2*WIDTH-1:0]   r_ext, x_ext, diff;
  logic [WIDTH+1:0]     rem_sh, trial, rem_nx;
  logic [WIDTH-1:0]     root_nx, root_rnd;

  always_comb begin
    r_ext  = (2*WIDTH)'(r_q);
    x_ext  = (2*WIDTH)'(x_q);
    diff   = r_ext * r_ext - x_ext * x_ext;
    // Remainder stays below 2^WIDTH before each shift, so no bits are lost here.
    rem_sh = {rem_q[WIDTH-1:0], rad_q[2*WIDTH-1 -: 2]};
    trial  = {root_q, 2'b01};
    if (rem_sh >= trial) begin
      rem_nx  = rem_sh - trial;
      root_nx = {root_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx  = rem_sh;
      root_nx = {root_q[WIDTH-2:0], 1'b0};
    end
    // rem > root is equivalent to diff >= (root + 0.5)^2.
    root_rnd = root_q;
    if (rem_q > {2'b00, root_q} && root_q != {WIDTH{1'b1}}) begin
      root_rnd = root_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      r_q         <= '0;
      x_q         <= '0;
      root_q      <= '0;
      rad_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      y_q         <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            r_q        <= r_in;
            x_q        <= x_in;
            in_ready_q <= 1'b0;
            state_q    <= StSquare;
          end
        end
        StSquare: begin
          if (x_q > r_q) begin
            err_q       <= 1'b1;
            y_q         <= '0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            rad_q   <= diff;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= CntW'(WIDTH - 1);
            state_q <= StRoot;
          end
        end
        StRoot: begin
          rad_q  <= rad_q << 2;
          rem_q  <= rem_nx;
          root_q <= root_nx;
          cnt_q  <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
`ifdef ROUND_HALF_EN
            state_q     <= StRound;
`else
            y_q         <= root_nx;
            err_q       <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
`endif
          end
        end
        StRound: begin
          y_q         <= root_rnd;
          err_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_pythag_leg_solver.sv
// Directed bench for pythag_leg_solver: hand-computed legs, latency, backpressure and abort.
module tb_pythag_leg_solver;

  localparam int unsigned WIDTH = 8;
`ifdef ROUND_HALF_EN
  localparam int FloorLat = WIDTH + 3;
  localparam int Y11x8    = 8;
  localparam int Y255x1   = 255;
`else
  localparam int FloorLat = WIDTH + 2;
  localparam int Y11x8    = 7;
  localparam int Y255x1   = 254;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] r_in, x_in, y_out;
  logic             in_valid, in_ready, err_out, out_valid, out_ready;

  int n_total = 0;
  int n_bad   = 0;

  pythag_leg_solver #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .r_in     (r_in),
    .x_in     (x_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y_out    (y_out),
    .err_out  (err_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one operand pair and returns edges from accept (inclusive) to out_valid.
  task automatic issue(input int r, input int x, output int lat);
    r_in     = WIDTH'(r);
    x_in     = WIDTH'(x);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input int r, input int x, input int ey,
                         input int eerr, input int elat);
    int lat;
    issue(r, x, lat);
    check_eq({tag, ".valid"}, int'(out_valid), 1);
    check_eq({tag, ".lat"}, lat, elat);
    check_eq({tag, ".y"}, int'(y_out), ey);
    check_eq({tag, ".err"}, int'(err_out), eerr);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, ".rdy_after"}, int'(in_ready), 1);
    check_eq({tag, ".vld_after"}, int'(out_valid), 0);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r_in      = '0;
    x_in      = '0;
    tick();
    tick();
    check_eq("rst.in_ready", int'(in_ready), 1);
    check_eq("rst.out_valid", int'(out_valid), 0);
    check_eq("rst.y", int'(y_out), 0);
    check_eq("rst.err", int'(err_out), 0);
    rst = 1'b0;
    tick();

    run_vec("r5x3",     5,   3,   4,      0, FloorLat);
    run_vec("r255x0",   255, 0,   255,    0, FloorLat);
    run_vec("r200x200", 200, 200, 0,      0, FloorLat);
    run_vec("r3x5",     3,   5,   0,      1, 2);
    run_vec("r11x8",    11,  8,   Y11x8,  0, FloorLat);
    run_vec("r9x4",     9,   4,   8,      0, FloorLat);
    run_vec("r255x1",   255, 1,   Y255x1, 0, FloorLat);

    // Backpressure: result held, new requests ignored while DONE.
    issue(5, 3, lat);
    check_eq("hold.lat", lat, FloorLat);
    for (int i = 0; i < 5; i++) begin
      r_in     = 8'd9;
      x_in     = 8'd0;
      in_valid = (i % 2) == 0;
      tick();
      check_eq("hold.valid", int'(out_valid), 1);
      check_eq("hold.y", int'(y_out), 4);
      check_eq("hold.in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("hold.release_rdy", int'(in_ready), 1);
    tick();
    tick();
    check_eq("hold.no_ghost", int'(out_valid), 0);
    check_eq("hold.idle_rdy", int'(in_ready), 1);

    // Abort in the middle of the root iterations.
    r_in     = 8'd13;
    x_in     = 8'd5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort.in_ready", int'(in_ready), 1);
    check_eq("abort.out_valid", int'(out_valid), 0);
    check_eq("abort.y", int'(y_out), 0);
    repeat (12) tick();
    check_eq("abort.no_result", int'(out_valid), 0);
    run_vec("r13x5", 13, 5, 12, 0, FloorLat);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
